// File: rtl/ahb_mst_inject_mux.sv
// N-channel AHB-Lite master injection mux: hands each channel between the CPU master
// and a testbench master at idle transfer boundaries, and keeps per-channel statistics.
module ahb_mst_inject_mux #(
    parameter int NUM_CH    = 3,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int CNT_W     = 16,
    parameter int TO_CYCLES = 256
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [NUM_CH-1:0]         mode_req,
    output logic [NUM_CH-1:0]         mode_ack,

    input  logic [NUM_CH*AW-1:0]      cpu_haddr,
    input  logic [NUM_CH*3-1:0]       cpu_hburst,
    input  logic [NUM_CH*4-1:0]       cpu_hprot,
    input  logic [NUM_CH*3-1:0]       cpu_hsize,
    input  logic [NUM_CH*2-1:0]       cpu_htrans,
    input  logic [NUM_CH*DW-1:0]      cpu_hwdata,
    input  logic [NUM_CH-1:0]         cpu_hwrite,

    input  logic [NUM_CH*AW-1:0]      tb_haddr,
    input  logic [NUM_CH*3-1:0]       tb_hburst,
    input  logic [NUM_CH*4-1:0]       tb_hprot,
    input  logic [NUM_CH*3-1:0]       tb_hsize,
    input  logic [NUM_CH*2-1:0]       tb_htrans,
    input  logic [NUM_CH*DW-1:0]      tb_hwdata,
    input  logic [NUM_CH-1:0]         tb_hwrite,

    output logic [NUM_CH*AW-1:0]      bus_haddr,
    output logic [NUM_CH*3-1:0]       bus_hburst,
    output logic [NUM_CH*4-1:0]       bus_hprot,
    output logic [NUM_CH*3-1:0]       bus_hsize,
    output logic [NUM_CH*2-1:0]       bus_htrans,
    output logic [NUM_CH*DW-1:0]      bus_hwdata,
    output logic [NUM_CH-1:0]         bus_hwrite,

    input  logic [NUM_CH*DW-1:0]      bus_hrdata,
    input  logic [NUM_CH-1:0]         bus_hready,
    input  logic [NUM_CH*2-1:0]       bus_hresp,

    output logic [NUM_CH*DW-1:0]      cpu_hrdata,
    output logic [NUM_CH-1:0]         cpu_hready,
    output logic [NUM_CH*2-1:0]       cpu_hresp,

    output logic [NUM_CH*DW-1:0]      tb_hrdata,
    output logic [NUM_CH-1:0]         tb_hready,
    output logic [NUM_CH*2-1:0]       tb_hresp,

    input  logic [NUM_CH-1:0]         stat_clr,
    output logic [NUM_CH*CNT_W-1:0]   xfer_cnt,
    output logic [NUM_CH-1:0]         timeout
);

    localparam logic [1:0]       HTRANS_IDLE = 2'b00;
    localparam logic [1:0]       HRESP_OKAY  = 2'b00;
    localparam int               SW          = $clog2(TO_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [SW-1:0]    STALL_MAX   = SW'(TO_CYCLES - 1);

    typedef enum logic [1:0] {
        S_CPU     = 2'd0,
        S_DRN_TB  = 2'd1,
        S_TB      = 2'd2,
        S_DRN_CPU = 2'd3
    } ch_state_e;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_e        state_q;
        ch_state_e        state_nxt;
        logic             tb_owns;
        logic             switch_ok;
        logic             accept;
        logic             stall_full;
        logic             ack_q;
        logic             to_q;
        logic [CNT_W-1:0] cnt_q;
        logic [SW-1:0]    stall_q;

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge hclk) begin
            if (!hreset_n) state_q <= S_CPU;
            else           state_q <= state_nxt;
        end

        // Ownership only moves when the current owner is idle and the bus is ready.
        assign switch_ok = (bus_htrans[g*2 +: 2] == HTRANS_IDLE) && bus_hready[g];

        always_comb begin
            // NOTE: default assignment first so no path through the case infers a latch.
            state_nxt = state_q;
            case (state_q)
                S_CPU:     if (mode_req[g]) state_nxt = S_DRN_TB;
                S_DRN_TB:  if (!mode_req[g]) state_nxt = S_CPU;
                           else if (switch_ok) state_nxt = S_TB;
                S_TB:      if (!mode_req[g]) state_nxt = S_DRN_CPU;
                S_DRN_CPU: if (mode_req[g]) state_nxt = S_TB;
                           else if (switch_ok) state_nxt = S_CPU;
                default:   state_nxt = S_CPU;
            endcase
        end

        always_comb begin
            tb_owns = (state_q == S_TB) || (state_q == S_DRN_CPU);
        end

        assign bus_haddr [g*AW +: AW] = tb_owns ? tb_haddr [g*AW +: AW] : cpu_haddr [g*AW +: AW];
        assign bus_hburst[g*3  +: 3]  = tb_owns ? tb_hburst[g*3  +: 3]  : cpu_hburst[g*3  +: 3];
        assign bus_hprot [g*4  +: 4]  = tb_owns ? tb_hprot [g*4  +: 4]  : cpu_hprot [g*4  +: 4];
        assign bus_hsize [g*3  +: 3]  = tb_owns ? tb_hsize [g*3  +: 3]  : cpu_hsize [g*3  +: 3];
        assign bus_htrans[g*2  +: 2]  = tb_owns ? tb_htrans[g*2  +: 2]  : cpu_htrans[g*2  +: 2];
        assign bus_hwdata[g*DW +: DW] = tb_owns ? tb_hwdata[g*DW +: DW] : cpu_hwdata[g*DW +: DW];
        assign bus_hwrite[g]          = tb_owns ? tb_hwrite[g]          : cpu_hwrite[g];

        // The non-owner sees a stalled OKAY so it parks in its address phase.
        assign cpu_hrdata[g*DW +: DW] = bus_hrdata[g*DW +: DW];
        assign tb_hrdata [g*DW +: DW] = bus_hrdata[g*DW +: DW];
        assign cpu_hready[g]          = !tb_owns && bus_hready[g];
        assign tb_hready [g]          =  tb_owns && bus_hready[g];
        assign cpu_hresp [g*2 +: 2]   = tb_owns ? HRESP_OKAY : bus_hresp[g*2 +: 2];
        assign tb_hresp  [g*2 +: 2]   = tb_owns ? bus_hresp[g*2 +: 2] : HRESP_OKAY;

        always_ff @(posedge hclk) begin
            if (!hreset_n) ack_q <= 1'b0;
            else           ack_q <= tb_owns;
        end

        assign accept     = bus_htrans[g*2 + 1] && bus_hready[g];
        assign stall_full = (stall_q == STALL_MAX);

        always_ff @(posedge hclk) begin
            if (!hreset_n || stat_clr[g]) begin
                cnt_q   <= '0;
                stall_q <= '0;
                to_q    <= 1'b0;
            end else begin
                if (accept && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);
                if (bus_hready[g])    stall_q <= '0;
                else if (!stall_full) stall_q <= stall_q + SW'(1);
                if (!bus_hready[g] && stall_full) to_q <= 1'b1;
            end
        end

        assign mode_ack[g]               = ack_q;
        assign timeout[g]                = to_q;
        assign xfer_cnt[g*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_ahb_mst_inject_mux.sv
// Scoreboard bench for ahb_mst_inject_mux: a per-channel reference model predicts every
// output each cycle; predictions are queued on drive and compared on the falling edge.
module tb_ahb_mst_inject_mux;

    localparam int NUM_CH    = 3;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int CNT_W     = 4;
    localparam int TO_CYCLES = 20;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic                    hclk;
    logic                    hreset_n;
    logic [NUM_CH-1:0]       mode_req, mode_ack;
    logic [NUM_CH*AW-1:0]    cpu_haddr, tb_haddr, bus_haddr;
    logic [NUM_CH*3-1:0]     cpu_hburst, tb_hburst, bus_hburst;
    logic [NUM_CH*4-1:0]     cpu_hprot, tb_hprot, bus_hprot;
    logic [NUM_CH*3-1:0]     cpu_hsize, tb_hsize, bus_hsize;
    logic [NUM_CH*2-1:0]     cpu_htrans, tb_htrans, bus_htrans;
    logic [NUM_CH*DW-1:0]    cpu_hwdata, tb_hwdata, bus_hwdata;
    logic [NUM_CH-1:0]       cpu_hwrite, tb_hwrite, bus_hwrite;
    logic [NUM_CH*DW-1:0]    bus_hrdata, cpu_hrdata, tb_hrdata;
    logic [NUM_CH-1:0]       bus_hready, cpu_hready, tb_hready;
    logic [NUM_CH*2-1:0]     bus_hresp, cpu_hresp, tb_hresp;
    logic [NUM_CH-1:0]       stat_clr, timeout;
    logic [NUM_CH*CNT_W-1:0] xfer_cnt;

    ahb_mst_inject_mux #(
        .NUM_CH(NUM_CH), .AW(AW), .DW(DW), .CNT_W(CNT_W), .TO_CYCLES(TO_CYCLES)
    ) dut (
        .hclk(hclk), .hreset_n(hreset_n), .mode_req(mode_req), .mode_ack(mode_ack),
        .cpu_haddr(cpu_haddr), .cpu_hburst(cpu_hburst), .cpu_hprot(cpu_hprot),
        .cpu_hsize(cpu_hsize), .cpu_htrans(cpu_htrans), .cpu_hwdata(cpu_hwdata),
        .cpu_hwrite(cpu_hwrite),
        .tb_haddr(tb_haddr), .tb_hburst(tb_hburst), .tb_hprot(tb_hprot),
        .tb_hsize(tb_hsize), .tb_htrans(tb_htrans), .tb_hwdata(tb_hwdata),
        .tb_hwrite(tb_hwrite),
        .bus_haddr(bus_haddr), .bus_hburst(bus_hburst), .bus_hprot(bus_hprot),
        .bus_hsize(bus_hsize), .bus_htrans(bus_htrans), .bus_hwdata(bus_hwdata),
        .bus_hwrite(bus_hwrite),
        .bus_hrdata(bus_hrdata), .bus_hready(bus_hready), .bus_hresp(bus_hresp),
        .cpu_hrdata(cpu_hrdata), .cpu_hready(cpu_hready), .cpu_hresp(cpu_hresp),
        .tb_hrdata(tb_hrdata), .tb_hready(tb_hready), .tb_hresp(tb_hresp),
        .stat_clr(stat_clr), .xfer_cnt(xfer_cnt), .timeout(timeout)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string                   tag;
        logic [NUM_CH*AW-1:0]    haddr;
        logic [NUM_CH*3-1:0]     hburst;
        logic [NUM_CH*4-1:0]     hprot;
        logic [NUM_CH*3-1:0]     hsize;
        logic [NUM_CH*2-1:0]     htrans;
        logic [NUM_CH*DW-1:0]    hwdata;
        logic [NUM_CH-1:0]       hwrite;
        logic [NUM_CH*DW-1:0]    rdata;
        logic [NUM_CH-1:0]       cpu_rdy, tb_rdy;
        logic [NUM_CH*2-1:0]     cpu_resp, tb_resp;
        logic [NUM_CH-1:0]       ack, to;
        logic [NUM_CH*CNT_W-1:0] cnt;
    } exp_t;

    exp_t  sb_q[$];
    string phase = "init";

    // Reference model: 0=CPU 1=DRN_TB 2=TB 3=DRN_CPU
    int m_st[NUM_CH];
    int m_cnt[NUM_CH];
    int m_stall[NUM_CH];
    bit m_to[NUM_CH];
    bit m_ack[NUM_CH];

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_stall[i] = 0; m_to[i] = 0; m_ack[i] = 0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < NUM_CH; i++) begin
            bit own, sw, acc, req;
            logic [1:0] tr;
            int nst;
            own = (m_st[i] >= 2);
            tr  = own ? tb_htrans[i*2 +: 2] : cpu_htrans[i*2 +: 2];
            sw  = (tr == IDLE) && bus_hready[i];
            acc = tr[1] && bus_hready[i];
            req = mode_req[i];
            case (m_st[i])
                0:       nst = req ? 1 : 0;
                1:       nst = !req ? 0 : (sw ? 2 : 1);
                2:       nst = req ? 2 : 3;
                3:       nst = req ? 2 : (sw ? 0 : 3);
                default: nst = 0;
            endcase
            if (!hreset_n) begin
                m_st[i] = 0; m_ack[i] = 0; m_cnt[i] = 0; m_stall[i] = 0; m_to[i] = 0;
            end else begin
                m_st[i]  = nst;
                m_ack[i] = own;
                if (stat_clr[i]) begin
                    m_cnt[i] = 0; m_stall[i] = 0; m_to[i] = 0;
                end else begin
                    if (acc && m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
                    if (!bus_hready[i] && m_stall[i] == TO_CYCLES - 1) m_to[i] = 1;
                    if (bus_hready[i]) m_stall[i] = 0;
                    else if (m_stall[i] < TO_CYCLES - 1) m_stall[i]++;
                end
            end
        end
    endtask

    // Called at posedge+1 with inputs set: predict, push, advance one clock.
    task automatic cycle();
        exp_t e;
        bus_hrdata = {$urandom, $urandom, $urandom};
        bus_hresp  = 6'($urandom);
        e.tag   = phase;
        e.rdata = bus_hrdata;
        for (int i = 0; i < NUM_CH; i++) begin
            bit own;
            own = (m_st[i] >= 2);
            e.haddr [i*AW +: AW] = own ? tb_haddr [i*AW +: AW] : cpu_haddr [i*AW +: AW];
            e.hburst[i*3 +: 3]   = own ? tb_hburst[i*3 +: 3]   : cpu_hburst[i*3 +: 3];
            e.hprot [i*4 +: 4]   = own ? tb_hprot [i*4 +: 4]   : cpu_hprot [i*4 +: 4];
            e.hsize [i*3 +: 3]   = own ? tb_hsize [i*3 +: 3]   : cpu_hsize [i*3 +: 3];
            e.htrans[i*2 +: 2]   = own ? tb_htrans[i*2 +: 2]   : cpu_htrans[i*2 +: 2];
            e.hwdata[i*DW +: DW] = own ? tb_hwdata[i*DW +: DW] : cpu_hwdata[i*DW +: DW];
            e.hwrite[i]          = own ? tb_hwrite[i]          : cpu_hwrite[i];
            e.cpu_rdy[i]         = own ? 1'b0 : bus_hready[i];
            e.tb_rdy[i]          = own ? bus_hready[i] : 1'b0;
            e.cpu_resp[i*2 +: 2] = own ? 2'b00 : bus_hresp[i*2 +: 2];
            e.tb_resp[i*2 +: 2]  = own ? bus_hresp[i*2 +: 2] : 2'b00;
            e.ack[i]             = m_ack[i];
            e.to[i]              = m_to[i];
            e.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        end
        sb_q.push_back(e);
        @(posedge hclk);
        model_update();
        #1;
    endtask

    always @(negedge hclk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({e.tag, "/bus_haddr"},  128'(bus_haddr),  128'(e.haddr));
            check({e.tag, "/bus_hburst"}, 128'(bus_hburst), 128'(e.hburst));
            check({e.tag, "/bus_hprot"},  128'(bus_hprot),  128'(e.hprot));
            check({e.tag, "/bus_hsize"},  128'(bus_hsize),  128'(e.hsize));
            check({e.tag, "/bus_htrans"}, 128'(bus_htrans), 128'(e.htrans));
            check({e.tag, "/bus_hwdata"}, 128'(bus_hwdata), 128'(e.hwdata));
            check({e.tag, "/bus_hwrite"}, 128'(bus_hwrite), 128'(e.hwrite));
            check({e.tag, "/cpu_hrdata"}, 128'(cpu_hrdata), 128'(e.rdata));
            check({e.tag, "/tb_hrdata"},  128'(tb_hrdata),  128'(e.rdata));
            check({e.tag, "/cpu_hready"}, 128'(cpu_hready), 128'(e.cpu_rdy));
            check({e.tag, "/tb_hready"},  128'(tb_hready),  128'(e.tb_rdy));
            check({e.tag, "/cpu_hresp"},  128'(cpu_hresp),  128'(e.cpu_resp));
            check({e.tag, "/tb_hresp"},   128'(tb_hresp),   128'(e.tb_resp));
            check({e.tag, "/mode_ack"},   128'(mode_ack),   128'(e.ack));
            check({e.tag, "/xfer_cnt"},   128'(xfer_cnt),   128'(e.cnt));
            check({e.tag, "/timeout"},    128'(timeout),    128'(e.to));
        end
    end

    task automatic set_cpu(input int ch, input logic [1:0] tr, input logic [AW-1:0] a);
        cpu_htrans[ch*2 +: 2]  = tr;
        cpu_haddr[ch*AW +: AW] = a;
        cpu_hwdata[ch*DW +: DW] = ~a;
        cpu_hwrite[ch]         = a[2];
        cpu_hsize[ch*3 +: 3]   = 3'b010;
        cpu_hburst[ch*3 +: 3]  = 3'b011;
        cpu_hprot[ch*4 +: 4]   = 4'b0011;
    endtask

    task automatic set_tb(input int ch, input logic [1:0] tr, input logic [AW-1:0] a);
        tb_htrans[ch*2 +: 2]   = tr;
        tb_haddr[ch*AW +: AW]  = a;
        tb_hwdata[ch*DW +: DW] = a ^ 32'h5a5a_a5a5;
        tb_hwrite[ch]          = ~a[3];
        tb_hsize[ch*3 +: 3]    = 3'b001;
        tb_hburst[ch*3 +: 3]   = 3'b001;
        tb_hprot[ch*4 +: 4]    = 4'b1010;
    endtask

    function automatic logic [1:0] rand_trans();
        int r;
        r = $urandom_range(0, 2);
        return (r == 0) ? IDLE : (r == 1) ? NONSEQ : SEQ;
    endfunction

    initial begin
        int n;
        bit ack_seen;
        int len[NUM_CH];

        hreset_n   = 1'b0;
        mode_req   = '0;
        stat_clr   = '0;
        bus_hready = '1;
        bus_hrdata = '0;
        bus_hresp  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            set_cpu(ch, IDLE, 32'h1000_0000 + ch * 32'h100);
            set_tb(ch, NONSEQ, 32'h2000_0000 + ch * 32'h100);
        end
        repeat (2) @(posedge hclk);
        #1;
        model_reset();

        phase = "reset";
        repeat (2) cycle();
        check("rst_mode_ack", 128'(mode_ack), 128'(0));
        check("rst_xfer_cnt", 128'(xfer_cnt), 128'(0));
        check("rst_timeout", 128'(timeout), 128'(0));
        check("rst_tb_hready", 128'(tb_hready), 128'(0));
        check("rst_bus_htrans", 128'(bus_htrans), 128'(0));
        check("rst_bus_haddr0", 128'(bus_haddr[31:0]), 128'(32'h1000_0000));
        hreset_n = 1'b1;
        cycle();

        // Handover while the CPU runs an INCR4 burst
        phase = "t2_drain";
        mode_req[0] = 1'b1;
        set_cpu(0, NONSEQ, 32'h1000_0000);
        cycle();
        for (int b = 1; b < 4; b++) begin
            set_cpu(0, SEQ, 32'h1000_0000 + b * 4);
            cycle();
        end
        check("t2_still_cpu", 128'(bus_haddr[31:0]), 128'(32'h1000_000C));
        set_cpu(0, IDLE, 32'h1000_0010);
        cycle();
        check("t2_tb_addr", 128'(bus_haddr[31:0]), 128'(32'h2000_0000));
        check("t2_tb_hready", 128'(tb_hready[0]), 128'(1));
        check("t2_cpu_hready", 128'(cpu_hready[0]), 128'(0));
        check("t2_ack_lag", 128'(mode_ack[0]), 128'(0));
        phase = "t2_tb";
        set_tb(0, SEQ, 32'h2000_0004);
        cycle();
        check("t2_ack", 128'(mode_ack[0]), 128'(1));
        mode_req[0] = 1'b0;
        set_tb(0, SEQ, 32'h2000_0008);
        cycle();
        set_tb(0, SEQ, 32'h2000_000C);
        cycle();
        set_tb(0, IDLE, 32'h2000_0010);
        cycle();
        check("t2_back_cpu", 128'(bus_haddr[31:0]), 128'(32'h1000_0010));
        check("t2_ack_hold", 128'(mode_ack[0]), 128'(1));
        set_tb(0, NONSEQ, 32'h2000_0000);

        // Request withdrawn before the CPU ever goes idle
        phase = "t3_abort";
        ack_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_cpu(0, (k == 0) ? NONSEQ : SEQ, 32'h1100_0000 + k * 4);
            mode_req[0] = (k == 2 || k == 3);
            cycle();
            ack_seen |= mode_ack[0];
        end
        check("t3_no_ack", 128'(ack_seen), 128'(0));
        check("t3_cpu_owns", 128'(bus_haddr[31:0]), 128'(32'h1100_001C));
        set_cpu(0, IDLE, 32'h1100_0020);
        cycle();

        // Transfer counting with wait states, then clear against an accept
        phase = "t4_count";
        stat_clr[1] = 1'b1;
        cycle();
        stat_clr[1] = 1'b0;
        check("t4_clr0", 128'(xfer_cnt[1*CNT_W +: CNT_W]), 128'(0));
        n = 0;
        for (int k = 0; k < 13; k++) begin
            bit stall;
            stall = (k == 3 || k == 7 || k == 8);
            bus_hready[1] = !stall;
            set_cpu(1, (n == 0) ? NONSEQ : SEQ, 32'h3000_0000 + n * 4);
            cycle();
            if (!stall) n++;
        end
        check("t4_cnt10", 128'(xfer_cnt[1*CNT_W +: CNT_W]), 128'(10));
        set_cpu(1, NONSEQ, 32'h3000_0100);
        stat_clr[1] = 1'b1;
        cycle();
        stat_clr[1] = 1'b0;
        set_cpu(1, IDLE, 32'h3000_0104);
        check("t4_clr_wins", 128'(xfer_cnt[1*CNT_W +: CNT_W]), 128'(0));
        cycle();

        // Stall timeout boundary, stickiness, clear
        phase = "t5_timeout";
        bus_hready[2] = 1'b0;
        repeat (TO_CYCLES - 1) cycle();
        check("t5_no_to", 128'(timeout[2]), 128'(0));
        cycle();
        check("t5_to", 128'(timeout[2]), 128'(1));
        bus_hready[2] = 1'b1;
        repeat (3) cycle();
        check("t5_sticky", 128'(timeout[2]), 128'(1));
        stat_clr[2] = 1'b1;
        cycle();
        stat_clr[2] = 1'b0;
        check("t5_clr", 128'(timeout[2]), 128'(0));

        // Counter saturation
        phase = "t6_sat";
        stat_clr[0] = 1'b1;
        cycle();
        stat_clr[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_cpu(0, (k == 0) ? NONSEQ : SEQ, 32'h1200_0000 + k * 4);
            cycle();
        end
        check("t6_cnt_sat", 128'(xfer_cnt[0*CNT_W +: CNT_W]), 128'(15));
        set_cpu(0, IDLE, 32'h1200_0050);
        cycle();

        // All channels switch concurrently, each at its own boundary
        phase = "t6_conc";
        len[0] = 1; len[1] = 3; len[2] = 5;
        mode_req = '1;
        for (int k = 0; k < 8; k++) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                set_cpu(ch, (k < len[ch]) ? SEQ : IDLE, 32'h4000_0000 + ch * 32'h100 + k * 4);
            cycle();
        end
        check("t6_all_tb_addr", 128'(bus_haddr), 128'(tb_haddr));
        check("t6_all_ack", 128'(mode_ack), 128'(3'b111));

        phase = "random";
        for (int k = 0; k < 300; k++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, 7) == 0) mode_req[ch] = ~mode_req[ch];
                set_cpu(ch, rand_trans(), $urandom);
                set_tb(ch, rand_trans(), $urandom);
                bus_hready[ch] = ($urandom_range(0, 3) != 0);
                stat_clr[ch]   = ($urandom_range(0, 31) == 0);
            end
            cycle();
        end
        stat_clr   = '0;
        bus_hready = '1;

        // Reset lands while every channel is draining back to the CPU
        phase = "rst_mid";
        mode_req = '1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            set_cpu(ch, IDLE, 32'h5000_0000 + ch * 32'h100);
            set_tb(ch, SEQ, 32'h6000_0000 + ch * 32'h100);
        end
        repeat (3) cycle();
        mode_req = '0;
        cycle();
        hreset_n = 1'b0;
        cycle();
        check("rst_mid_owner", 128'(bus_haddr), 128'(cpu_haddr));
        check("rst_mid_ack", 128'(mode_ack), 128'(0));
        check("rst_mid_cnt", 128'(xfer_cnt), 128'(0));
        hreset_n = 1'b1;
        repeat (3) cycle();

        @(negedge hclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
